// File: rtl/cam_pkg.sv
// Shared definitions for the DVP camera capture path.
package cam_pkg;

   // Depth of the pin synchronizers (all DVP inputs use the same depth).
   localparam int unsigned SYNC_STAGES = 2;

   // Capture state machine.
   typedef enum logic [1:0] {
      IDLE,
      WAIT_FRAME,
      ACTIVE,
      DROP
   } cap_state_t;

endpackage

// File: rtl/dvp_sync.sv
// DVP pin synchronizer: brings PCLK/HREF/VSYNC/D into the core clock domain
// with equal delay and turns them into single-cycle event pulses.
module dvp_sync
   import cam_pkg::*;
#(
   parameter bit PCLK_RISING       = 1'b1,
   parameter bit VSYNC_ACTIVE_HIGH = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cam_pclk,
   input  logic [7:0] cam_d,
   input  logic       cam_href,
   input  logic       cam_vsync,
   output logic       byte_stb,
   output logic [7:0] pix_byte,
   output logic       line_end,
   output logic       vs_rise,
   output logic       vs_fall
);

   // Reset VSYNC to its blanking-inactive level so reset does not look like a frame edge.
   localparam logic VS_IDLE = ~VSYNC_ACTIVE_HIGH;

   logic [SYNC_STAGES-1:0] pclk_sync;
   logic [SYNC_STAGES-1:0] href_sync;
   logic [SYNC_STAGES-1:0] vs_sync;
   logic [7:0]             d_sync [SYNC_STAGES];
   logic                   pclk_d3;
   logic                   href_d3;
   logic                   vs_act_q;

   logic                   pclk_s;
   logic                   href_s;
   logic                   vs_act;
   logic                   cap_edge;

   // Synchronizer chains plus the extra delay stage used for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         pclk_sync <= '0;
         href_sync <= '0;
         vs_sync   <= {SYNC_STAGES{VS_IDLE}};
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            d_sync[i] <= '0;
         end
         pclk_d3   <= 1'b0;
         href_d3   <= 1'b0;
      end else begin
         pclk_sync <= {pclk_sync[SYNC_STAGES-2:0], cam_pclk};
         href_sync <= {href_sync[SYNC_STAGES-2:0], cam_href};
         vs_sync   <= {vs_sync[SYNC_STAGES-2:0], cam_vsync};
         d_sync[0] <= cam_d;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            d_sync[i] <= d_sync[i-1];
         end
         pclk_d3   <= pclk_sync[SYNC_STAGES-1];
         href_d3   <= href_sync[SYNC_STAGES-1];
      end
   end

   // Edge selection and VSYNC polarity normalisation.
   always_comb begin
      pclk_s   = pclk_sync[SYNC_STAGES-1];
      href_s   = href_sync[SYNC_STAGES-1];
      vs_act   = VSYNC_ACTIVE_HIGH ? vs_sync[SYNC_STAGES-1] : ~vs_sync[SYNC_STAGES-1];
      cap_edge = PCLK_RISING ? (pclk_s & ~pclk_d3) : (~pclk_s & pclk_d3);
   end

   // Registered event pulses towards the capture FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_stb <= 1'b0;
         pix_byte <= '0;
         line_end <= 1'b0;
         vs_act_q <= 1'b0;
         vs_rise  <= 1'b0;
         vs_fall  <= 1'b0;
      end else begin
         byte_stb <= cap_edge & href_s;
         if (cap_edge && href_s) begin
            pix_byte <= d_sync[SYNC_STAGES-1];
         end
         line_end <= href_d3 & ~href_s;
         vs_act_q <= vs_act;
         vs_rise  <= vs_act & ~vs_act_q;
         vs_fall  <= ~vs_act & vs_act_q;
      end
   end

endmodule

// File: rtl/dvp_capture_axis.sv
// OV2640 DVP capture to AXI-Stream bytes, with per-frame statistics and
// sticky overflow reporting.
module dvp_capture_axis
   import cam_pkg::*;
#(
   parameter bit          PCLK_RISING       = 1'b1,
   parameter bit          VSYNC_ACTIVE_HIGH = 1'b1,
   parameter int unsigned LINE_W            = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cam_pclk,
   input  logic [7:0]        cam_d,
   input  logic              cam_href,
   input  logic              cam_vsync,
   input  logic              enable,
   output logic [7:0]        m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast,
   output logic              m_axis_tuser,
   output logic [15:0]       frame_count,
   output logic [LINE_W-1:0] last_line_bytes,
   output logic [LINE_W-1:0] last_frame_lines,
   output logic              overflow,
   input  logic              overflow_clr
);

   cap_state_t        state;
   cap_state_t        state_nxt;

   logic              byte_stb;
   logic [7:0]        pix_byte;
   logic              line_end;
   logic              vs_rise;
   logic              vs_fall;

   logic              hold_valid;
   logic [7:0]        hold_data;
   logic              sof_pending;
   logic [LINE_W-1:0] byte_cnt;
   logic [LINE_W-1:0] line_cnt;

   logic              push_req;
   logic              push_last;
   logic              push_ok;
   logic              drop;
   logic              load_hold;
   logic              clear_hold;
   logic              line_done;
   logic              frame_done;
   logic              frame_start;

   dvp_sync #(
      .PCLK_RISING       (PCLK_RISING),
      .VSYNC_ACTIVE_HIGH (VSYNC_ACTIVE_HIGH)
   ) u_sync (
      .clk       (clk),
      .rst       (rst),
      .cam_pclk  (cam_pclk),
      .cam_d     (cam_d),
      .cam_href  (cam_href),
      .cam_vsync (cam_vsync),
      .byte_stb  (byte_stb),
      .pix_byte  (pix_byte),
      .line_end  (line_end),
      .vs_rise   (vs_rise),
      .vs_fall   (vs_fall)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and per-cycle datapath decisions; frame end outranks line end,
   // line end outranks a new byte.
   always_comb begin
      state_nxt   = state;
      push_req    = 1'b0;
      push_last   = 1'b0;
      load_hold   = 1'b0;
      clear_hold  = 1'b0;
      line_done   = 1'b0;
      frame_done  = 1'b0;
      frame_start = 1'b0;
      case (state)
         IDLE: begin
            if (vs_rise && enable) begin
               state_nxt = WAIT_FRAME;
            end
         end
         WAIT_FRAME: begin
            if (vs_fall) begin
               state_nxt   = ACTIVE;
               frame_start = 1'b1;
            end
         end
         ACTIVE: begin
            if (vs_rise) begin
               // A byte still held here means HREF never fell: close the line now.
               push_req   = hold_valid;
               push_last  = 1'b1;
               clear_hold = 1'b1;
               frame_done = 1'b1;
               state_nxt  = enable ? WAIT_FRAME : IDLE;
            end else if (line_end) begin
               push_req   = hold_valid;
               push_last  = 1'b1;
               clear_hold = 1'b1;
               line_done  = 1'b1;
            end else if (byte_stb) begin
               push_req   = hold_valid;
               push_last  = 1'b0;
               load_hold  = 1'b1;
            end
         end
         DROP: begin
            if (vs_rise) begin
               state_nxt = enable ? WAIT_FRAME : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      push_ok = push_req & (~m_axis_tvalid | m_axis_tready);
      drop    = push_req & ~push_ok;
      if (drop && !frame_done) begin
         state_nxt = DROP;
      end
   end

   // One-byte hold register and start-of-frame marker.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_valid  <= 1'b0;
         hold_data   <= '0;
         sof_pending <= 1'b0;
      end else begin
         if (drop || clear_hold) begin
            hold_valid <= 1'b0;
         end else if (load_hold) begin
            hold_valid <= 1'b1;
            hold_data  <= pix_byte;
         end
         if (frame_start) begin
            sof_pending <= 1'b1;
         end else if (push_ok) begin
            sof_pending <= 1'b0;
         end
      end
   end

   // Single AXI-Stream output stage; contents frozen while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
      end else begin
         if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
         if (push_ok) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= hold_data;
            m_axis_tlast  <= push_last;
            m_axis_tuser  <= sof_pending;
         end
      end
   end

   // Line/frame statistics; dropped frames are not reported.
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt         <= '0;
         line_cnt         <= '0;
         last_line_bytes  <= '0;
         last_frame_lines <= '0;
         frame_count      <= '0;
      end else begin
         if (frame_start || line_done) begin
            byte_cnt <= '0;
         end else if (load_hold && byte_cnt != '1) begin
            byte_cnt <= byte_cnt + 1'b1;
         end
         if (line_done) begin
            last_line_bytes <= byte_cnt;
         end
         if (frame_start) begin
            line_cnt <= '0;
         end else if (line_done && line_cnt != '1) begin
            line_cnt <= line_cnt + 1'b1;
         end
         if (frame_done && !drop) begin
            last_frame_lines <= line_cnt;
            frame_count      <= frame_count + 16'd1;
         end
      end
   end

   // Sticky overflow; a new drop wins over a clear in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (overflow_clr) begin
         overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dvp_capture_axis.sv
// Self-checking bench for dvp_capture_axis: camera byte stream model with a
// scoreboard of expected AXI-Stream beats.
module tb_dvp_capture_axis;

   localparam int unsigned MODE_NONE  = 0;
   localparam int unsigned MODE_EXACT = 1;
   localparam int unsigned MODE_LOOSE = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cam_pclk = 1'b0;
   logic [7:0]  cam_d = '0;
   logic        cam_href = 1'b0;
   logic        cam_vsync = 1'b0;
   logic        enable = 1'b1;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;
   logic        m_axis_tlast;
   logic        m_axis_tuser;
   logic [15:0] frame_count;
   logic [11:0] last_line_bytes;
   logic [11:0] last_frame_lines;
   logic        overflow;
   logic        overflow_clr = 1'b0;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned hs_count = 0;
   int unsigned hs_mark = 0;
   int unsigned exp_frames = 0;
   bit          loose = 1'b0;
   bit          hit;
   logic [9:0]  exp_q [$];
   logic [9:0]  loose_q [$];
   logic [9:0]  mon_word;
   logic [31:0] mon_want;

   dvp_capture_axis #(
      .PCLK_RISING       (1'b1),
      .VSYNC_ACTIVE_HIGH (1'b1),
      .LINE_W            (12)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .cam_pclk         (cam_pclk),
      .cam_d            (cam_d),
      .cam_href         (cam_href),
      .cam_vsync        (cam_vsync),
      .enable           (enable),
      .m_axis_tdata     (m_axis_tdata),
      .m_axis_tvalid    (m_axis_tvalid),
      .m_axis_tready    (m_axis_tready),
      .m_axis_tlast     (m_axis_tlast),
      .m_axis_tuser     (m_axis_tuser),
      .frame_count      (frame_count),
      .last_line_bytes  (last_line_bytes),
      .last_frame_lines (last_frame_lines),
      .overflow         (overflow),
      .overflow_clr     (overflow_clr)
   );

   // 100 MHz core clock, ~12 MHz camera pixel clock.
   always #5 clk = ~clk;
   always #42 cam_pclk = ~cam_pclk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_exp(input int unsigned mode, input logic [9:0] word);
      if (mode == MODE_EXACT) exp_q.push_back(word);
      else if (mode == MODE_LOOSE) loose_q.push_back(word);
   endtask

   // One HREF line of nb bytes starting at base, then a short gap.
   task automatic send_line(input logic [7:0] base, input int unsigned nb,
                            input int unsigned mode, input bit first);
      logic [7:0] v;
      for (int unsigned i = 0; i < nb; i++) begin
         v = base + 8'(i);
         @(negedge cam_pclk);
         cam_href = 1'b1;
         cam_d    = v;
         push_exp(mode, {first && (i == 0), i == nb - 1, v});
      end
      @(negedge cam_pclk);
      cam_href = 1'b0;
      cam_d    = '0;
      repeat (4) @(negedge cam_pclk);
   endtask

   task automatic send_frame(input logic [7:0] base, input int unsigned mode);
      for (int unsigned l = 0; l < 4; l++) begin
         send_line(base + 8'(8 * l), 8, mode, l == 0);
      end
   endtask

   task automatic vsync_pulse();
      @(negedge cam_pclk);
      cam_vsync = 1'b1;
      repeat (6) @(negedge cam_pclk);
      cam_vsync = 1'b0;
      repeat (6) @(negedge cam_pclk);
   endtask

   // Drop tready right after a fresh beat appears, so the stall really bites.
   task automatic stall_on_valid(output bit found);
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #3;
         if (m_axis_tvalid) begin
            m_axis_tready = 1'b0;
            found = 1'b1;
            break;
         end
      end
   endtask

   // Scoreboard: every handshake is matched against the expected queue.
   always @(negedge clk) begin
      if (!rst && m_axis_tvalid && m_axis_tready) begin
         hs_count++;
         mon_word = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
         if (loose) begin
            while (loose_q.size() > 0 && loose_q[0] != mon_word) void'(loose_q.pop_front());
            mon_want = (loose_q.size() > 0) ? {22'b0, loose_q[0]} : 32'hFFFF_FFFF;
            if (loose_q.size() > 0) void'(loose_q.pop_front());
            check_eq("drop_frame_beat", {22'b0, mon_word}, mon_want);
         end else begin
            mon_want = (exp_q.size() > 0) ? {22'b0, exp_q.pop_front()} : 32'hFFFF_FFFF;
            check_eq("stream_beat", {22'b0, mon_word}, mon_want);
         end
      end
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (5) @(posedge clk);
      #3 rst = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_tvalid", m_axis_tvalid, 0);
      check_eq("rst_tlast", m_axis_tlast, 0);
      check_eq("rst_tuser", m_axis_tuser, 0);
      check_eq("rst_tdata", m_axis_tdata, 0);
      check_eq("rst_frame_count", frame_count, 0);
      check_eq("rst_line_bytes", last_line_bytes, 0);
      check_eq("rst_frame_lines", last_frame_lines, 0);
      check_eq("rst_overflow", overflow, 0);

      // Two clean frames.
      vsync_pulse();
      send_frame(8'h00, MODE_EXACT);
      vsync_pulse();
      send_frame(8'h00, MODE_EXACT);
      vsync_pulse();
      exp_frames = 2;
      check_eq("frames_two", frame_count, exp_frames);
      check_eq("line_bytes_8", last_line_bytes, 8);
      check_eq("frame_lines_4", last_frame_lines, 4);
      check_eq("queue_drained_1", exp_q.size(), 0);

      // Short backpressure mid-line: nothing lost.
      fork
         send_frame(8'h20, MODE_EXACT);
         begin
            @(posedge cam_href);
            repeat (20) @(posedge clk);
            stall_on_valid(hit);
            check_eq("bp_stall_hit", hit, 1);
            repeat (2) @(posedge clk);
            #3 m_axis_tready = 1'b1;
         end
      join
      vsync_pulse();
      exp_frames++;
      check_eq("bp_no_overflow", overflow, 0);
      check_eq("bp_frames", frame_count, exp_frames);
      check_eq("queue_drained_2", exp_q.size(), 0);

      // Long stall: overflow, rest of the frame suppressed and not counted.
      loose = 1'b1;
      fork
         send_frame(8'h40, MODE_LOOSE);
         begin
            @(posedge cam_href);
            repeat (20) @(posedge clk);
            stall_on_valid(hit);
            check_eq("ovf_stall_hit", hit, 1);
            #1000;
            @(posedge clk);
            #3 m_axis_tready = 1'b1;
            repeat (5) @(posedge clk);
            hs_mark = hs_count;
         end
      join
      check_eq("ovf_set", overflow, 1);
      vsync_pulse();
      loose = 1'b0;
      loose_q.delete();
      check_eq("ovf_silent_after", hs_count, hs_mark);
      check_eq("ovf_frame_not_counted", frame_count, exp_frames);

      // Recovery frame; enable dropped before its closing VSYNC.
      send_frame(8'h60, MODE_EXACT);
      enable = 1'b0;
      vsync_pulse();
      exp_frames++;
      check_eq("recover_frames", frame_count, exp_frames);
      check_eq("ovf_sticky", overflow, 1);
      @(posedge clk);
      #3 overflow_clr = 1'b1;
      @(posedge clk);
      #3 overflow_clr = 1'b0;
      @(negedge clk);
      check_eq("ovf_cleared", overflow, 0);

      // Disabled frame, then enable raised mid-frame: silence until next pulse.
      hs_mark = hs_count;
      send_frame(8'h80, MODE_NONE);
      vsync_pulse();
      send_line(8'hA0, 8, MODE_NONE, 1'b1);
      enable = 1'b1;
      for (int unsigned l = 1; l < 4; l++) send_line(8'hA0 + 8'(8 * l), 8, MODE_NONE, 1'b0);
      check_eq("enable_off_silent", hs_count, hs_mark);
      check_eq("enable_off_frames", frame_count, exp_frames);
      vsync_pulse();
      send_frame(8'hC0, MODE_EXACT);
      vsync_pulse();
      exp_frames++;
      check_eq("enable_on_frames", frame_count, exp_frames);
      check_eq("queue_drained_3", exp_q.size(), 0);

      // VSYNC arrives while HREF is still high after 5 bytes.
      send_line(8'hE0, 8, MODE_EXACT, 1'b1);
      send_line(8'hE8, 8, MODE_EXACT, 1'b0);
      for (int unsigned i = 0; i < 5; i++) begin
         @(negedge cam_pclk);
         cam_href = 1'b1;
         cam_d    = 8'hF0 + 8'(i);
         push_exp(MODE_EXACT, {1'b0, i == 4, 8'hF0 + 8'(i)});
      end
      @(negedge cam_pclk);
      cam_vsync = 1'b1;
      cam_d     = 8'hF5;
      repeat (3) @(negedge cam_pclk);
      cam_href  = 1'b0;
      repeat (6) @(negedge cam_pclk);
      cam_vsync = 1'b0;
      repeat (6) @(negedge cam_pclk);
      exp_frames++;
      check_eq("vs_in_line_frames", frame_count, exp_frames);
      check_eq("queue_drained_4", exp_q.size(), 0);
      send_frame(8'h00, MODE_EXACT);
      vsync_pulse();
      exp_frames++;
      check_eq("after_vs_line_frames", frame_count, exp_frames);

      // Reset after 3 bytes of a line.
      loose = 1'b1;
      for (int unsigned i = 0; i < 3; i++) begin
         @(negedge cam_pclk);
         cam_href = 1'b1;
         cam_d    = 8'h50 + 8'(i);
         push_exp(MODE_LOOSE, {i == 0, 1'b0, 8'h50 + 8'(i)});
      end
      @(posedge cam_pclk);
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      @(negedge clk);
      check_eq("mid_rst_tvalid", m_axis_tvalid, 0);
      check_eq("mid_rst_tlast", m_axis_tlast, 0);
      check_eq("mid_rst_tuser", m_axis_tuser, 0);
      check_eq("mid_rst_tdata", m_axis_tdata, 0);
      check_eq("mid_rst_frame_count", frame_count, 0);
      check_eq("mid_rst_line_bytes", last_line_bytes, 0);
      check_eq("mid_rst_frame_lines", last_frame_lines, 0);
      repeat (2) @(negedge cam_pclk);
      cam_href = 1'b0;
      repeat (4) @(negedge cam_pclk);
      loose = 1'b0;
      loose_q.delete();
      vsync_pulse();
      send_frame(8'h70, MODE_EXACT);
      vsync_pulse();
      check_eq("post_rst_frames", frame_count, 1);
      check_eq("post_rst_line_bytes", last_line_bytes, 8);
      check_eq("post_rst_frame_lines", last_frame_lines, 4);
      check_eq("queue_drained_final", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
